fifo_pkt_reader: RTL and testbench

- Read-side controller that sits directly downstream of the router packet FIFO, in the FIFO's read clock domain.
- Whenever the FIFO is non-empty, it walks the head entry byte-by-byte through the FIFO's raddr_in index and presents the packet on a valid/ready byte stream with sop/eop framing.
- After the last byte is accepted, it pops the entry with a single rinc pulse.

---
 rtl/fifo_pkt_reader.sv | 148 ++++++++++++++
 tb/tb_fifo_pkt_reader.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_pkt_reader.sv
// -----------------------------------------------------------------------------
// fifo_pkt_reader
//
// Read-side controller for the router packet FIFO, living in the FIFO read
// clock domain. While the FIFO is non-empty it walks the head entry byte by
// byte through raddr_in, presents each byte on a valid/ready stream with
// sop/eop framing, and pops the entry with a single rinc pulse once the last
// byte has been accepted downstream.
//
// Byte 0 of an entry is the header: length in [PTR_IN_SZ-1:0], destination
// in [UWIDTH-1:PTR_IN_SZ]. A length beyond WIDTH-1 is clamped to WIDTH-1 and
// raises the sticky len_err flag.
//
// Optional build macro: PKT_RD_CNT_EN adds a 16-bit wrapping pkt_cnt output
// that counts popped entries.
//
// Ports:
//   clk        clock (FIFO read clock)
//   rst        asynchronous reset, active-low
//   rempty     FIFO empty flag
//   rdata      FIFO byte at [head entry][raddr_in], combinational
//   raddr_in   byte index into the head entry
//   rinc       pop the head entry (one-cycle pulse)
//   out_data   stream byte (registered)
//   out_valid  stream byte valid
//   out_ready  downstream accepts the byte
//   out_sop    first byte of packet (header)
//   out_eop    last byte of packet
//   out_dest   destination field of the current header
//   pkt_cnt    popped-entry counter (PKT_RD_CNT_EN only)
//   len_err    sticky: a header length exceeded WIDTH-1
// -----------------------------------------------------------------------------
module fifo_pkt_reader #(
  parameter int WIDTH     = 11,
  parameter int UWIDTH    = 8,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rempty,
  input  logic [UWIDTH-1:0]           rdata,
  output logic [PTR_IN_SZ-1:0]        raddr_in,
  output logic                        rinc,
  output logic [UWIDTH-1:0]           out_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_sop,
  output logic                        out_eop,
  output logic [UWIDTH-PTR_IN_SZ-1:0] out_dest,
`ifdef PKT_RD_CNT_EN
  output logic [15:0]                 pkt_cnt,
`endif
  output logic                        len_err
);

  localparam logic [PTR_IN_SZ-1:0] MAX_IDX = PTR_IN_SZ'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    POP   = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [PTR_IN_SZ-1:0]   idx;
  logic [PTR_IN_SZ-1:0]   leff;

  logic                   hdr_first;
  logic [PTR_IN_SZ-1:0]   hdr_len;
  logic [PTR_IN_SZ-1:0]   leff_cur;

  // Clamp a header length to the last valid byte index of an entry.
  function automatic logic [PTR_IN_SZ-1:0] sat_len(input logic [PTR_IN_SZ-1:0] len);
    return (len > MAX_IDX) ? MAX_IDX : len;
  endfunction

  // While fetching the header the stored length is stale, so the eop compare
  // has to use the length being decoded from rdata in the same cycle.
  assign hdr_first = (idx == '0);
  assign hdr_len   = rdata[PTR_IN_SZ-1:0];
  assign leff_cur  = hdr_first ? sat_len(hdr_len) : leff;

  assign raddr_in  = idx;
  assign rinc      = (state == POP);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!rempty) state_nxt = FETCH;
      FETCH:   state_nxt = SEND;
      SEND:    if (out_ready) state_nxt = out_eop ? POP : FETCH;
      POP:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx       <= '0;
      leff      <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_dest  <= '0;
      len_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: idx <= '0;
        FETCH: begin
          out_data  <= rdata;
          out_valid <= 1'b1;
          out_sop   <= hdr_first;
          out_eop   <= (idx == leff_cur);
          if (hdr_first) begin
            leff     <= leff_cur;
            out_dest <= rdata[UWIDTH-1:PTR_IN_SZ];
            if (hdr_len > MAX_IDX) len_err <= 1'b1;
          end
        end
        SEND: begin
          // Byte stays presented, untouched, until the consumer takes it.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (!out_eop) idx <= idx + PTR_IN_SZ'(1);
          end
        end
        POP: idx <= '0;
        default: idx <= '0;
      endcase
    end
  end

`ifdef PKT_RD_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              pkt_cnt <= 16'd0;
    else if (state == POP) pkt_cnt <= pkt_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_pkt_reader.sv
module tb_fifo_pkt_reader;

  logic        clk = 1'b0;
  logic        rst;
  logic        rempty;
  logic [7:0]  rdata;
  logic [3:0]  raddr_in;
  logic        rinc;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;
  logic [3:0]  out_dest;
  logic        len_err;
`ifdef PKT_RD_CNT_EN
  logic [15:0] pkt_cnt;
`endif

  // FIFO model: 8 entries of 16 bytes, head/tail pointers.
  logic [7:0] mem [0:7][0:15];
  logic [2:0] head = 3'd0;
  logic [2:0] tail = 3'd0;
  assign rempty = (head == tail);
  assign rdata  = mem[head][raddr_in];

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic [3:0] idx;
    logic [3:0] dest;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] ent [0:15];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rinc_cnt = 0;
  int   rinc_base = 0;
  int   sop_cyc = 0;
  int   prev_sop_cyc = 0;
  int   stall_left = 0;
  logic [3:0] stall_idx = 4'd0;
  logic [7:0] stall_data = 8'd0;
  logic [3:0] raddr_max = 4'd0;
  logic       eop_prev = 1'b0;

  fifo_pkt_reader #(.WIDTH(11), .UWIDTH(8), .PTR_IN_SZ(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .rempty    (rempty),
    .rdata     (rdata),
    .raddr_in  (raddr_in),
    .rinc      (rinc),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sop   (out_sop),
    .out_eop   (out_eop),
    .out_dest  (out_dest),
`ifdef PKT_RD_CNT_EN
    .pkt_cnt   (pkt_cnt),
`endif
    .len_err   (len_err)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected byte stream of the entry in the given slot.
  task automatic push_exp(input logic [2:0] slot);
    logic [3:0] l;
    logic [3:0] le;
    exp_t e;
    l  = mem[slot][0][3:0];
    le = (l > 4'd10) ? 4'd10 : l;
    for (int i = 0; i <= int'(le); i++) begin
      e.d    = mem[slot][i];
      e.sop  = (i == 0);
      e.eop  = (i == int'(le));
      e.idx  = 4'(i);
      e.dest = mem[slot][0][7:4];
      sb.push_back(e);
    end
  endtask

  task automatic push_ent();
    for (int i = 0; i < 16; i++) mem[tail][i] = ent[i];
    push_exp(tail);
    tail = tail + 3'd1;
  endtask

  task automatic set_ent(input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 16; i++) ent[i] = 8'h00;
    ent[0] = b0; ent[1] = b1; ent[2] = b2; ent[3] = b3;
  endtask

  // One clock: drive out_ready and check outputs on the falling edge, then
  // retire a popped entry just after the rising edge.
  task automatic step();
    logic pop;
    exp_t e;
    pop = 1'b0;
    @(negedge clk);
    cyc++;
    if (out_valid && stall_left > 0 && raddr_in == stall_idx) begin
      out_ready = 1'b0;
      stall_left--;
      chk("stall_data", 32'(out_data), 32'(stall_data));
    end else begin
      out_ready = 1'b1;
    end
    if (rinc || eop_prev) chk("rinc_timing", 32'(rinc), 32'(eop_prev));
    if (rinc) begin
      chk("rinc_nonempty", 32'(rempty), 32'd0);
      rinc_cnt++;
      pop = 1'b1;
    end
    eop_prev = 1'b0;
    if (raddr_in > raddr_max) raddr_max = raddr_in;
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_byte", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(out_data), 32'(e.d));
        chk("sop", 32'(out_sop), 32'(e.sop));
        chk("eop", 32'(out_eop), 32'(e.eop));
        chk("raddr", 32'(raddr_in), 32'(e.idx));
        chk("dest", 32'(out_dest), 32'(e.dest));
        if (out_sop) begin
          prev_sop_cyc = sop_cyc;
          sop_cyc = cyc;
        end
        eop_prev = out_eop;
      end
    end
    @(posedge clk);
    #1;
    if (pop) head = head + 3'd1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    repeat (3) step();
  endtask

  initial begin
    int n;
    for (int s = 0; s < 8; s++)
      for (int i = 0; i < 16; i++) mem[s][i] = 8'h00;
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_sop", 32'(out_sop), 32'd0);
    chk("rst_eop", 32'(out_eop), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_dest", 32'(out_dest), 32'd0);
    chk("rst_raddr", 32'(raddr_in), 32'd0);
    chk("rst_rinc", 32'(rinc), 32'd0);
    chk("rst_len_err", 32'(len_err), 32'd0);
`ifdef PKT_RD_CNT_EN
    chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
`endif
    rst = 1'b1;
    step();

    // Basic 4-byte packet.
    set_ent(8'h23, 8'hAA, 8'hBB, 8'hCC);
    rinc_base = rinc_cnt;
    push_ent();
    drain(100);
    chk("t1_rinc", 32'(rinc_cnt - rinc_base), 32'd1);
    chk("t1_dest", 32'(out_dest), 32'h2);
    chk("t1_len_err", 32'(len_err), 32'd0);

    // Back-pressure for three cycles on byte 0xBB.
    stall_idx = 4'd2;
    stall_data = 8'hBB;
    stall_left = 3;
    rinc_base = rinc_cnt;
    push_ent();
    drain(100);
    chk("t2_stall_done", 32'(stall_left), 32'd0);
    chk("t2_rinc", 32'(rinc_cnt - rinc_base), 32'd1);

    // Header-only packet.
    set_ent(8'h50, 8'h77, 8'h88, 8'h99);
    raddr_max = 4'd0;
    rinc_base = rinc_cnt;
    push_ent();
    drain(100);
    chk("t3_raddr_max", 32'(raddr_max), 32'd0);
    chk("t3_dest", 32'(out_dest), 32'h5);
    chk("t3_rinc", 32'(rinc_cnt - rinc_base), 32'd1);

    // Oversized length: clamped to 11 bytes.
    for (int i = 0; i < 16; i++) ent[i] = 8'(8'h10 + i);
    ent[0] = 8'h1F;
    rinc_base = rinc_cnt;
    push_ent();
    drain(200);
    chk("t4_len_err", 32'(len_err), 32'd1);
    chk("t4_dest", 32'(out_dest), 32'h1);
    chk("t4_rinc", 32'(rinc_cnt - rinc_base), 32'd1);

    // Two back-to-back entries.
    rinc_base = rinc_cnt;
    set_ent(8'h23, 8'hAA, 8'hBB, 8'hCC);
    push_ent();
    set_ent(8'h32, 8'h41, 8'h42, 8'h00);
    push_ent();
    drain(200);
    chk("t5_spacing", 32'(sop_cyc - prev_sop_cyc), 32'd10);
    chk("t5_rinc", 32'(rinc_cnt - rinc_base), 32'd2);
    chk("t5_dest", 32'(out_dest), 32'h3);
    chk("t5_len_err_sticky", 32'(len_err), 32'd1);
`ifdef PKT_RD_CNT_EN
    chk("t5_pkt_cnt", 32'(pkt_cnt), 32'(rinc_cnt));
`endif

    // Reset while byte 2 is being presented; entry must be replayed.
    set_ent(8'h23, 8'hAA, 8'hBB, 8'hCC);
    push_ent();
    n = 0;
    while (!(out_valid && raddr_in == 4'd2) && n < 50) begin
      step();
      n++;
    end
    chk("t6_reach_byte2", 32'(out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_sop", 32'(out_sop), 32'd0);
    chk("t6_eop", 32'(out_eop), 32'd0);
    chk("t6_dest", 32'(out_dest), 32'd0);
    chk("t6_raddr", 32'(raddr_in), 32'd0);
    chk("t6_rinc", 32'(rinc), 32'd0);
    chk("t6_len_err", 32'(len_err), 32'd0);
    sb.delete();
    push_exp(head);
    eop_prev = 1'b0;
    rinc_base = rinc_cnt;
    step();
    rst = 1'b1;
    drain(100);
    chk("t6_rinc", 32'(rinc_cnt - rinc_base), 32'd1);
    chk("t6_len_err_after", 32'(len_err), 32'd0);
`ifdef PKT_RD_CNT_EN
    chk("t6_pkt_cnt", 32'(pkt_cnt), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
